// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//
// Purpose:
//   Memory stage of a pipelined CPU. It latches the EX/MEM contents into an
//   internal request register (R), issues at most one load or store to the
//   data cache, and stalls the pipeline until the cache answers with dhit.
//   Completed instructions are registered onto the wb_* outputs that feed
//   the MEM/WB latch.
//
// Optional feature:
//   MEM_STAGE_LLSC_EN  - when defined, adds a link register (address and
//                        valid bit) for load-linked / store-conditional.
//                        A failing SC issues no access and writes 0.
//                        When undefined, LL is a plain load and SC is a
//                        plain store that always writes 1.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   ex_*                EX/MEM latch contents (valid, ALU result/address,
//                       store data, dest reg, reg write enable, WB mux
//                       select, load/store/LL/SC flags)
//   flush               turn the incoming EX instruction into a bubble
//   dhit, dload         cache completion strobe and read data
//   dmemREN, dmemWEN,
//   dmemaddr, dmemstore cache request
//   mem_stall           freeze all upstream latches this cycle
//   wb_*                registered outputs to the MEM/WB latch
// ----------------------------------------------------------------------------
module mem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [31:0] ex_porto,
    input  logic [31:0] ex_store,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_regen,
    input  logic [1:0]  ex_regsrc,
    input  logic        ex_memren,
    input  logic        ex_memwen,
    input  logic        ex_ll,
    input  logic        ex_sc,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [31:0] wb_porto,
    output logic [31:0] wb_dmemload,
    output logic [4:0]  wb_wsel,
    output logic        wb_regen,
    output logic [1:0]  wb_regsrc
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic        r_valid;
    logic [31:0] r_porto;
    logic [31:0] r_store;
    logic [4:0]  r_wsel;
    logic        r_regen;
    logic [1:0]  r_regsrc;
    logic        r_memren;
    logic        r_memwen;
    logic        r_sc;

    logic w_load;
    logic w_exValid;
    logic w_exMemren;
    logic w_exMemwen;
    logic w_exMemOp;
    logic w_complete;
    logic w_scResult;

    // R reloads whenever the stage is not stalled, so flush is implicitly
    // ignored during a stall.
    assign w_load    = ~mem_stall;
    assign w_exValid = ex_valid & ~flush;

    // An instruction completes either as a non-memory op sitting in R while
    // IDLE, or as a memory access that the cache has just acknowledged.
    assign w_complete = ((r_state == IDLE) & r_valid) | ((r_state == ACCESS) & dhit);

    // SC never reads memory; LL is a read.
    assign w_exMemren = (ex_memren | ex_ll) & ~ex_sc;

`ifdef MEM_STAGE_LLSC_EN
    logic [31:0] r_linkAddr;
    logic        r_linkValid;
    logic [31:0] w_linkAddrNext;
    logic        w_linkValidNext;
    logic        w_exScOk;
    logic        r_ll;
    logic        r_scOk;

    // The link state as it will be after this edge. SC success is judged
    // against it so an LL or store completing on the same edge the SC
    // enters R is already taken into account.
    always_comb begin
        w_linkAddrNext  = r_linkAddr;
        w_linkValidNext = r_linkValid;
        if (w_complete) begin
            if (r_ll && r_memren) begin
                w_linkAddrNext  = r_porto;
                w_linkValidNext = 1'b1;
            end
            if (r_memwen && (r_porto == r_linkAddr)) begin
                w_linkValidNext = 1'b0;
            end
            if (r_sc) begin
                w_linkValidNext = 1'b0;
            end
        end
    end

    assign w_exScOk   = ex_sc & w_linkValidNext & (w_linkAddrNext == ex_porto);
    assign w_exMemwen = ex_sc ? w_exScOk : ex_memwen;
    assign w_scResult = r_scOk;

    // Link register; cleared by reset, otherwise follows the next-state view.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_linkAddr  <= 32'd0;
            r_linkValid <= 1'b0;
        end else begin
            r_linkAddr  <= w_linkAddrNext;
            r_linkValid <= w_linkValidNext;
        end
    end
`else
    assign w_exMemwen = ex_memwen | ex_sc;
    assign w_scResult = 1'b1;
`endif

    assign w_exMemOp = w_exValid & (w_exMemren | w_exMemwen);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: ACCESS exactly when R will hold a valid memory op after
    // this edge; a pending access without dhit keeps its state.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    w_stateNext = w_exMemOp ? ACCESS : IDLE;
            ACCESS:  begin
                if (dhit) begin
                    w_stateNext = w_exMemOp ? ACCESS : IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Cache request and stall. A store beats a load when both flags are set.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        dmemaddr  = r_porto;
        dmemstore = r_store;
        if (r_state == ACCESS) begin
            dmemREN   = r_memren & ~r_memwen;
            dmemWEN   = r_memwen;
            mem_stall = ~dhit;
        end
    end

    // Request register R; the memory flags stored here are the effective
    // ones, already masked by bubble and SC outcome.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid  <= 1'b0;
            r_porto  <= 32'd0;
            r_store  <= 32'd0;
            r_wsel   <= 5'd0;
            r_regen  <= 1'b0;
            r_regsrc <= 2'd0;
            r_memren <= 1'b0;
            r_memwen <= 1'b0;
            r_sc     <= 1'b0;
`ifdef MEM_STAGE_LLSC_EN
            r_ll     <= 1'b0;
            r_scOk   <= 1'b0;
`endif
        end else if (w_load) begin
            r_valid  <= w_exValid;
            r_porto  <= ex_porto;
            r_store  <= ex_store;
            r_wsel   <= ex_wsel;
            r_regen  <= ex_regen;
            r_regsrc <= ex_regsrc;
            r_memren <= w_exValid & w_exMemren;
            r_memwen <= w_exValid & w_exMemwen;
            r_sc     <= w_exValid & ex_sc;
`ifdef MEM_STAGE_LLSC_EN
            r_ll     <= w_exValid & ex_ll & ~ex_sc;
            r_scOk   <= w_exScOk;
`endif
        end
    end

    // MEM/WB outputs. Without a completion only valid and regen drop; the
    // remaining fields hold so downstream sees stable data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_porto    <= 32'd0;
            wb_dmemload <= 32'd0;
            wb_wsel     <= 5'd0;
            wb_regen    <= 1'b0;
            wb_regsrc   <= 2'd0;
        end else if (w_complete) begin
            wb_valid  <= 1'b1;
            wb_porto  <= r_porto;
            wb_wsel   <= r_wsel;
            wb_regen  <= r_regen;
            wb_regsrc <= r_regsrc;
            if (r_sc) begin
                wb_dmemload <= {31'd0, w_scResult};
            end else if (r_memren && !r_memwen) begin
                wb_dmemload <= dload;
            end
        end else begin
            wb_valid <= 1'b0;
            wb_regen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
//
// Purpose:
//   Self-checking bench for mem_stage. Accepted instructions push their
//   expected MEM/WB result (and expected cache access, if any) into queues;
//   a monitor pops and compares on every wb_valid, and a cache responder
//   pops and compares on every dhit it returns. Directed sequences cover
//   ALU ops, stalled loads and stores, flush, store-over-load priority,
//   LL/SC (both builds, via MEM_STAGE_LLSC_EN), dhit while idle and reset
//   during an access.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_porto = '0;
    logic [31:0] ex_store = '0;
    logic [4:0]  ex_wsel = '0;
    logic        ex_regen = 1'b0;
    logic [1:0]  ex_regsrc = '0;
    logic        ex_memren = 1'b0;
    logic        ex_memwen = 1'b0;
    logic        ex_ll = 1'b0;
    logic        ex_sc = 1'b0;
    logic        flush = 1'b0;
    logic        dhit = 1'b0;
    logic [31:0] dload = '0;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_porto;
    logic [31:0] wb_dmemload;
    logic [4:0]  wb_wsel;
    logic        wb_regen;
    logic [1:0]  wb_regsrc;

    mem_stage dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_porto(ex_porto), .ex_store(ex_store),
        .ex_wsel(ex_wsel), .ex_regen(ex_regen), .ex_regsrc(ex_regsrc),
        .ex_memren(ex_memren), .ex_memwen(ex_memwen), .ex_ll(ex_ll), .ex_sc(ex_sc),
        .flush(flush), .dhit(dhit), .dload(dload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_porto(wb_porto), .wb_dmemload(wb_dmemload),
        .wb_wsel(wb_wsel), .wb_regen(wb_regen), .wb_regsrc(wb_regsrc)
    );

    always #5 CLK = ~CLK;

`ifdef MEM_STAGE_LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    typedef struct {
        logic [31:0] porto;
        logic [4:0]  wsel;
        logic        regen;
        logic [1:0]  regsrc;
        logic [31:0] dmemload;
    } wbExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } accExp_t;

    wbExp_t  expectQ[$];
    accExp_t accessQ[$];
    wbExp_t  monExp;
    accExp_t respAcc;

    int checkCount = 0;
    int errorCount = 0;

    int          waitCycles = 0;
    int          respCnt = 0;
    bit          responderEnable = 1'b1;
    logic        forceDhit = 1'b0;
    logic [31:0] forceDload = '0;

    logic [31:0] mDmemload = '0;
    logic        mLinkValid = 1'b0;
    logic [31:0] mLinkAddr = '0;

    // Cache contents model: every address reads back a fixed scramble.
    function automatic logic [31:0] memModel(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Cache responder: waits waitCycles cycles into each access, then
    // answers with dhit for one cycle and checks the request against the
    // access queue. When disabled, dhit/dload follow forced values.
    always @(negedge CLK) begin
        if (!responderEnable) begin
            respCnt = 0;
            dhit    = forceDhit;
            dload   = forceDload;
        end else if (dhit) begin
            dhit    = 1'b0;
            respCnt = 0;
        end else if (dmemREN || dmemWEN) begin
            if (respCnt >= waitCycles) begin
                dhit  = 1'b1;
                dload = memModel(dmemaddr);
                if (accessQ.size() == 0) begin
                    checkOutput("accessUnexpected", 32'(dmemREN | dmemWEN), 32'd0);
                end else begin
                    respAcc = accessQ.pop_front();
                    checkOutput("accessWEN", 32'(dmemWEN), 32'(respAcc.we));
                    checkOutput("accessREN", 32'(dmemREN), 32'(!respAcc.we));
                    checkOutput("accessAddr", dmemaddr, respAcc.addr);
                    if (respAcc.we) begin
                        checkOutput("accessData", dmemstore, respAcc.data);
                    end
                end
            end else begin
                respCnt++;
            end
        end
    end

    // Output monitor: compares every completion against the scoreboard and
    // checks invariants each cycle.
    always @(posedge CLK) begin
        #1;
        checkOutput("regenWithoutValid", 32'(wb_regen & ~wb_valid), 32'd0);
        checkOutput("bothStrobes", 32'(dmemREN & dmemWEN), 32'd0);
        if (wb_valid === 1'b1) begin
            if (expectQ.size() == 0) begin
                checkOutput("wbUnexpected", 32'(wb_valid), 32'd0);
            end else begin
                monExp = expectQ.pop_front();
                checkOutput("wbPorto", wb_porto, monExp.porto);
                checkOutput("wbWsel", 32'(wb_wsel), 32'(monExp.wsel));
                checkOutput("wbRegen", 32'(wb_regen), 32'(monExp.regen));
                checkOutput("wbRegsrc", 32'(wb_regsrc), 32'(monExp.regsrc));
                checkOutput("wbDmemload", wb_dmemload, monExp.dmemload);
            end
        end
    end

    // Drives the EX/MEM inputs for one instruction.
    task automatic driveOp(input logic [31:0] porto, input logic [31:0] store, input logic [4:0] wsel,
                           input logic regen, input logic [1:0] regsrc, input logic memren,
                           input logic memwen, input logic ll, input logic sc, input logic fl);
        ex_valid  = 1'b1;
        ex_porto  = porto;
        ex_store  = store;
        ex_wsel   = wsel;
        ex_regen  = regen;
        ex_regsrc = regsrc;
        ex_memren = memren;
        ex_memwen = memwen;
        ex_ll     = ll;
        ex_sc     = sc;
        flush     = fl;
    endtask

    // Behavioural model of the instruction being accepted: pushes the
    // expected write-back result and cache access.
    task automatic modelOp();
        wbExp_t  e;
        accExp_t a;
        logic    isStore;
        logic    isLoad;
        logic    scOk;
        if (!ex_valid || flush) return;
        scOk = 1'b1;
`ifdef MEM_STAGE_LLSC_EN
        if (ex_sc) begin
            scOk       = mLinkValid && (mLinkAddr == ex_porto);
            mLinkValid = 1'b0;
        end
        isStore = ex_sc ? scOk : ex_memwen;
`else
        isStore = ex_memwen | ex_sc;
`endif
        isLoad = !isStore && !ex_sc && (ex_memren || ex_ll);
`ifdef MEM_STAGE_LLSC_EN
        if (isStore && (ex_porto == mLinkAddr)) mLinkValid = 1'b0;
        if (isLoad && ex_ll) begin
            mLinkAddr  = ex_porto;
            mLinkValid = 1'b1;
        end
`endif
        if (ex_sc) mDmemload = {31'd0, scOk};
        else if (isLoad) mDmemload = memModel(ex_porto);
        e.porto    = ex_porto;
        e.wsel     = ex_wsel;
        e.regen    = ex_regen;
        e.regsrc   = ex_regsrc;
        e.dmemload = mDmemload;
        expectQ.push_back(e);
        if (isStore || isLoad) begin
            a.we   = isStore;
            a.addr = ex_porto;
            a.data = ex_store;
            accessQ.push_back(a);
        end
    endtask

    // Presents one instruction, waits (bounded) until the stage accepts it,
    // records the expectation and returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] porto, input logic [31:0] store, input logic [4:0] wsel,
                                 input logic regen, input logic [1:0] regsrc, input logic memren,
                                 input logic memwen, input logic ll, input logic sc, input logic fl);
        int guard;
        @(negedge CLK);
        driveOp(porto, store, wsel, regen, regsrc, memren, memwen, ll, sc, fl);
        #2;
        guard = 0;
        while (mem_stall === 1'b1 && guard < 100) begin
            @(negedge CLK);
            #2;
            guard++;
        end
        if (guard >= 100) checkOutput("stallTimeout", 32'(mem_stall), 32'd0);
        modelOp();
        @(posedge CLK);
        #1;
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic aluOp(input logic [31:0] porto, input logic [4:0] wsel, input logic regen, input logic fl);
        applyStimulus(porto, 32'd0, wsel, regen, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
    endtask

    task automatic loadOp(input logic [31:0] addr, input logic [4:0] wsel);
        applyStimulus(addr, 32'd0, wsel, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic storeOp(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(addr, data, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic llOp(input logic [31:0] addr, input logic [4:0] wsel);
        applyStimulus(addr, 32'd0, wsel, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic scOp(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] wsel);
        applyStimulus(addr, data, wsel, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Waits (bounded) until every expected completion has been observed.
    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expectQ.size() != 0 || accessQ.size() != 0) && guard < 200) begin
            @(posedge CLK);
            #2;
            guard++;
        end
        checkOutput("drain", 32'(expectQ.size() + accessQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting mem_stage bench, LLSC build = %0d", LLSC);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #2;
        checkOutput("rstWbValid", 32'(wb_valid), 32'd0);
        checkOutput("rstWbRegen", 32'(wb_regen), 32'd0);
        checkOutput("rstWbPorto", wb_porto, 32'd0);
        checkOutput("rstWbDmemload", wb_dmemload, 32'd0);
        checkOutput("rstWbWsel", 32'(wb_wsel), 32'd0);
        checkOutput("rstWbRegsrc", 32'(wb_regsrc), 32'd0);
        checkOutput("rstREN", 32'(dmemREN), 32'd0);
        checkOutput("rstStall", 32'(mem_stall), 32'd0);

        // ALU op reaches write-back one edge after entering R, no stall.
        aluOp(32'h10, 5'd3, 1'b1, 1'b0);
        @(negedge CLK); #2;
        checkOutput("aluNoStall", 32'(mem_stall), 32'd0);
        @(posedge CLK); #2;
        checkOutput("aluWbValid", 32'(wb_valid), 32'd1);
        checkOutput("aluWbPorto", wb_porto, 32'h10);
        checkOutput("aluWbWsel", 32'(wb_wsel), 32'd3);

        // Flushed ALU op produces nothing; fields hold.
        aluOp(32'h20, 5'd4, 1'b1, 1'b1);
        @(posedge CLK); #2;
        checkOutput("flushWbValid", 32'(wb_valid), 32'd0);
        checkOutput("flushWbRegen", 32'(wb_regen), 32'd0);
        checkOutput("flushWbPortoHold", wb_porto, 32'h10);

        // Load with three stall cycles.
        waitCycles = 3;
        loadOp(32'h100, 5'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #2;
            checkOutput("loadStall", 32'(mem_stall), 32'd1);
            checkOutput("loadREN", 32'(dmemREN), 32'd1);
            checkOutput("loadAddr", dmemaddr, 32'h100);
        end
        @(negedge CLK); #2;
        checkOutput("loadHitNoStall", 32'(mem_stall), 32'd0);
        @(posedge CLK); #2;
        checkOutput("loadData", wb_dmemload, 32'hDEADBEEF);

        // Store with flush raised during the stall.
        storeOp(32'h200, 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            driveOp(32'h30, 32'd0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            #2;
            checkOutput("storeStall", 32'(mem_stall), 32'd1);
            checkOutput("storeWEN", 32'(dmemWEN), 32'd1);
            checkOutput("storeData", dmemstore, 32'h55);
        end
        @(negedge CLK);
        flush = 1'b0;
        #2;
        checkOutput("storeHitNoStall", 32'(mem_stall), 32'd0);
        modelOp();
        @(posedge CLK); #1;
        ex_valid = 1'b0;
        @(posedge CLK); #2;
        checkOutput("afterStoreValid", 32'(wb_valid), 32'd1);
        checkOutput("afterStorePorto", wb_porto, 32'h30);

        // Both memory flags set: the store wins.
        waitCycles = 1;
        applyStimulus(32'h240, 32'h99, 5'd2, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        waitDrain();

        // Random mix of ALU ops, loads, stores and flushed bubbles.
        for (int i = 0; i < 16; i++) begin
            int          kind;
            logic [31:0] addr;
            kind       = int'($urandom_range(0, 3));
            waitCycles = int'($urandom_range(0, 2));
            addr       = 32'($urandom_range(0, 1023)) << 2;
            case (kind)
                0: aluOp(addr, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 1'b0);
                1: loadOp(addr, 5'($urandom_range(1, 31)));
                2: storeOp(addr, 32'($urandom));
                default: aluOp(addr, 5'd9, 1'b1, 1'b1);
            endcase
        end
        waitDrain();

        // LL / SC sequence (plain load/store semantics without the feature).
        waitCycles = 1;
        llOp(32'h300, 5'd8);
        scOp(32'h300, 32'h77, 5'd9);
        waitDrain();
        checkOutput("sc1Result", wb_dmemload, 32'd1);
        scOp(32'h300, 32'h78, 5'd10);
        @(negedge CLK); #2;
        checkOutput("sc2WEN", 32'(dmemWEN), 32'(!LLSC));
        waitDrain();
        checkOutput("sc2Result", wb_dmemload, 32'(!LLSC));
        llOp(32'h500, 5'd11);
        storeOp(32'h500, 32'hAB);
        scOp(32'h500, 32'hCD, 5'd12);
        waitDrain();

        // dhit while idle is ignored.
        responderEnable = 1'b0;
        forceDhit       = 1'b1;
        forceDload      = 32'h12345678;
        aluOp(32'h44, 5'd6, 1'b1, 1'b0);
        @(negedge CLK); #2;
        checkOutput("idleDhitREN", 32'(dmemREN), 32'd0);
        checkOutput("idleDhitStall", 32'(mem_stall), 32'd0);
        @(posedge CLK); #2;
        checkOutput("idleDhitPorto", wb_porto, 32'h44);
        checkOutput("idleDhitLoadHold", wb_dmemload, mDmemload);
        forceDhit = 1'b0;
        waitDrain();

        // Reset in the middle of an access abandons it.
        loadOp(32'h400, 5'd13);
        @(negedge CLK); #2;
        checkOutput("preRstREN", 32'(dmemREN), 32'd1);
        checkOutput("preRstStall", 32'(mem_stall), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #2;
        RST = 1'b0;
        expectQ.delete();
        accessQ.delete();
        mDmemload  = '0;
        mLinkValid = 1'b0;
        @(negedge CLK); #2;
        checkOutput("postRstREN", 32'(dmemREN), 32'd0);
        checkOutput("postRstWEN", 32'(dmemWEN), 32'd0);
        checkOutput("postRstStall", 32'(mem_stall), 32'd0);
        checkOutput("postRstWbValid", 32'(wb_valid), 32'd0);
        checkOutput("postRstWbPorto", wb_porto, 32'd0);
        checkOutput("postRstWbDmemload", wb_dmemload, 32'd0);

        // Normal operation resumes after reset.
        responderEnable = 1'b1;
        aluOp(32'h60, 5'd1, 1'b1, 1'b0);
        loadOp(32'h140, 5'd2);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
